pipelined_carry_select_adder: RTL and testbench
===============================================

Name: pipelined_carry_select_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor for the wide-adder datapath; successor to the fixed 4-bit carry-select slice.
- Operand width is split into BLOCK-wide carry-select segments. Each segment computes sums for carry-in 0 and 1 and muxes on the incoming carry.
- Pipeline registers are inserted every SEG_PER_STAGE segments.
- Valid/ready handshake on both sides, add/subtract mode, and status flags (carry, signed overflow, zero).

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of BLOCK*SEG_PER_STAGE.
- BLOCK, 4, carry-select segment width in bits.
- SEG_PER_STAGE, 1, segments evaluated per pipeline stage; LAT = WIDTH/(BLOCK*SEG_PER_STAGE) (16/4/1 gives 4).

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; ignored when Sub=1.
- Sub  input  1  0: A+B+Cin; 1: A+~B+1 (A-B).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry out of MSB; for Sub, 1 means no borrow.
- Overflow  output  1  signed overflow: carry into MSB XOR Cout.
- Zero  output  1  Sum == 0.

Behaviour:
- Reset (Reset_n low, async): all stage valid bits cleared; out_valid=0, Sum=0, Cout=0, Overflow=0, Zero=0. in_ready is 1 on the first edge after release. Reset mid-operation discards all in-flight beats with no partial output.
- Operand prep at stage-0 capture: Bx = Sub ? ~B : B, c0 = Sub ? 1 : Cin.
- Pipeline contents: LAT stages. Stage k holds:
  - the upper unprocessed slice of A and Bx,
  - the completed lower Sum bits,
  - the running carry,
  - the carry into the current MSB position,
  - a valid bit.
- Stage k evaluation: evaluates its SEG_PER_STAGE segments. Each segment forms sum0/cout0 (cin=0) and sum1/cout1 (cin=1), then selects with the incoming carry. Segment cout = carry ? cout1 : cout0.
- Last stage: registers Sum, Cout, Overflow and Zero, and asserts out_valid.
- Latency: a beat accepted at edge t appears on outputs after edge t+LAT-1 (out_valid high in the cycle following that edge). Default latency is 4 cycles.
- Throughput: one beat per cycle when out_ready=1.
- Advance: advance = !out_valid || out_ready. When advance=1, every stage shifts forward by one. When advance=0, the whole pipeline holds; bubbles are not compressed.
- in_ready = advance. A beat transfers on in_valid && in_ready. in_valid low inserts a bubble (valid=0) into stage 0.
- Output handshake: out_valid stays high and Sum/Cout/Overflow/Zero stay stable until out_valid && out_ready. A new result may replace the old one in the same cycle it is accepted.
- Ordering: results emerge in acceptance order; no beat is dropped or duplicated under any out_ready pattern.
- Arithmetic: modulo 2^WIDTH; Cout is the true carry out of bit WIDTH-1.
- Data registers of invalid stages may hold any value. Flags are only meaningful when out_valid=1.
- Elaboration error if WIDTH % (BLOCK*SEG_PER_STAGE) != 0 or BLOCK < 1.

Test Plan:
- Default parameters, A=0xFFFF, B=0x0001, Cin=0, Sub=0 -> 4 cycles later out_valid=1, Sum=0x0000, Cout=1, Zero=1, Overflow=0.
- A=0x7FFF, B=0x0001, Cin=0, Sub=0 -> Sum=0x8000, Cout=0, Overflow=1; then A=0x0005, B=0x0007, Sub=1, Cin=1 -> Sum=0xFFFE, Cout=0, Overflow=0 (Cin ignored).
- Carry across every segment boundary: A=0x0FFF, B=0x0001, Cin=0 -> Sum=0x1000; A=0x1234, B=0x4321, Cin=1 -> Sum=0x5556. Sweep 10k random A/B/Cin/Sub, out_ready=1 -> matches a reference model, one result per cycle after 4-cycle fill.
- Backpressure: stream 8 beats back-to-back, drop out_ready for 3 cycles mid-stream -> in_ready low those 3 cycles, outputs held stable, all 8 results in order, none lost or duplicated.
- Reset mid-operation: 3 beats in flight, pulse Reset_n low between edges -> out_valid=0 immediately; after release no stale result appears; a new beat returns after exactly 4 cycles.
- Rebuild with WIDTH=32, BLOCK=8, SEG_PER_STAGE=2 (LAT=2): A=0xFFFFFFFF, B=0x00000001 -> Sum=0, Cout=1 after 2 cycles; random sweep matches the reference model.

Source files
------------

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder
//   Parametrised carry-select adder/subtractor. The operand is cut into
//   BLOCK-bit segments. Each segment computes both carry-in candidates and
//   selects one with the incoming carry. A pipeline register follows every
//   SEG_PER_STAGE segments, which gives LAT = WIDTH/(BLOCK*SEG_PER_STAGE)
//   stages. Stage 0 captures directly from the operand ports.
//
// Ports
//   Clk, Reset_n         clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand beat handshake (in_ready = pipeline advances)
//   A, B, Cin, Sub       operands; Sub=1 computes A-B and ignores Cin
//   out_valid/out_ready  result beat handshake
//   Sum                  result, modulo 2^WIDTH
//   Cout                 carry out of the MSB (for Sub, 1 = no borrow)
//   Overflow             signed overflow
//   Zero                 Sum == 0
module pipelined_carry_select_adder #(
    parameter int WIDTH         = 16,
    parameter int BLOCK         = 4,
    parameter int SEG_PER_STAGE = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero
);

    localparam int STAGE_W = (BLOCK < 1 || SEG_PER_STAGE < 1) ? 1 : BLOCK * SEG_PER_STAGE;
    localparam int LAT     = (WIDTH / STAGE_W < 1) ? 1 : WIDTH / STAGE_W;
    localparam logic [BLOCK:0] ONE = 1;

    if (BLOCK < 1 || SEG_PER_STAGE < 1 || WIDTH < 1 || (WIDTH % STAGE_W) != 0) begin : g_param_check
        $error("pipelined_carry_select_adder: WIDTH must be a non-zero multiple of BLOCK*SEG_PER_STAGE");
    end

    // Per-stage state. Each stage keeps full-width copies; only the upper,
    // not yet processed part of a/bx and the lower, completed part of s matter.
    logic [WIDTH-1:0] a_q  [LAT];
    logic [WIDTH-1:0] bx_q [LAT];
    logic [WIDTH-1:0] s_q  [LAT];
    logic [WIDTH-1:0] a_d  [LAT];
    logic [WIDTH-1:0] bx_d [LAT];
    logic [WIDTH-1:0] s_d  [LAT];
    logic [LAT-1:0]   c_q, c_d;    // running carry
    logic [LAT-1:0]   cm_q, cm_d;  // carry into the top processed bit
    logic [LAT-1:0]   v_q, v_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             advance;

    // Evaluation temporaries
    logic [WIDTH-1:0] a_in, bx_in, s_in;
    logic             c_in, cm_in, v_in;
    logic [BLOCK:0]   r0, r1;
    int unsigned      base, top;

    assign advance  = !v_q[LAT-1] || out_ready;
    assign in_ready = advance;

    always_comb begin
        a_d    = a_q;
        bx_d   = bx_q;
        s_d    = s_q;
        c_d    = c_q;
        cm_d   = cm_q;
        v_d    = v_q;
        a_in   = '0;
        bx_in  = '0;
        s_in   = '0;
        c_in   = 1'b0;
        cm_in  = 1'b0;
        v_in   = 1'b0;
        r0     = '0;
        r1     = '0;
        base   = 0;
        top    = 0;
        for (int unsigned k = 0; k < LAT; k++) begin
            if (k == 0) begin
                // Operand preparation: subtraction is A + ~B + 1.
                a_in  = A;
                bx_in = Sub ? ~B : B;
                s_in  = '0;
                c_in  = Sub ? 1'b1 : Cin;
                cm_in = 1'b0;
                v_in  = in_valid;
            end else begin
                a_in  = a_q[k-1];
                bx_in = bx_q[k-1];
                s_in  = s_q[k-1];
                c_in  = c_q[k-1];
                cm_in = cm_q[k-1];
                v_in  = v_q[k-1];
            end
            for (int unsigned j = 0; j < SEG_PER_STAGE; j++) begin
                base = (k * SEG_PER_STAGE + j) * BLOCK;
                // Both candidates are formed independently; the carry only steers the mux.
                r0 = {1'b0, a_in[base +: BLOCK]} + {1'b0, bx_in[base +: BLOCK]};
                r1 = {1'b0, a_in[base +: BLOCK]} + {1'b0, bx_in[base +: BLOCK]} + ONE;
                s_in[base +: BLOCK] = c_in ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
                c_in                = c_in ? r1[BLOCK] : r0[BLOCK];
            end
            // Carry into the top bit of this stage's slice, recovered from its sum bit.
            top   = (k + 1) * STAGE_W - 1;
            cm_in = s_in[top] ^ a_in[top] ^ bx_in[top];
            a_d[k]  = a_in;
            bx_d[k] = bx_in;
            s_d[k]  = s_in;
            c_d[k]  = c_in;
            cm_d[k] = cm_in;
            v_d[k]  = v_in;
        end
        ovf_d  = c_d[LAT-1] ^ cm_d[LAT-1];
        zero_d = (s_d[LAT-1] == '0);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
            end
            c_q    <= '0;
            cm_q   <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            a_q    <= a_d;
            bx_q   <= bx_d;
            s_q    <= s_d;
            c_q    <= c_d;
            cm_q   <= cm_d;
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q[LAT-1];
    assign Sum       = s_q[LAT-1];
    assign Cout      = c_q[LAT-1];
    assign Overflow  = ovf_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench for pipelined_carry_select_adder. Two instances:
// default 16/4/1 (LAT=4) and 32/8/2 (LAT=2). Results are compared against a
// plain-arithmetic reference model and hand-derived directed vectors.
module tb_pipelined_carry_select_adder;

    localparam int LAT  = 4;
    localparam int LAT2 = 2;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] A, B, Sum;
    logic        Cin, Sub, Cout, Overflow, Zero;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [31:0] w_A, w_B, w_Sum;
    logic        w_Cin, w_Sub, w_Cout, w_Overflow, w_Zero;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4), .SEG_PER_STAGE(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Overflow(Overflow), .Zero(Zero));

    pipelined_carry_select_adder #(.WIDTH(32), .BLOCK(8), .SEG_PER_STAGE(2)) dut_w (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .A(w_A), .B(w_B), .Cin(w_Cin), .Sub(w_Sub), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .Sum(w_Sum), .Cout(w_Cout), .Overflow(w_Overflow), .Zero(w_Zero));

    // Reference: w-bit two's-complement add/subtract using 64-bit arithmetic.
    function automatic res_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        longint unsigned mask, al, bl, full;
        res_t r;
        mask = (64'd1 << w) - 64'd1;
        al   = {32'd0, a} & mask;
        bl   = {32'd0, b};
        bl   = (sub ? ~bl : bl) & mask;
        full = al + bl + (sub ? 64'd1 : {63'd0, cin});
        r.sum  = full[31:0] & mask[31:0];
        r.cout = full[w];
        r.ovf  = (al[w-1] == bl[w-1]) && (full[w-1] != al[w-1]);
        r.zero = ((full & mask) == 64'd0);
        return r;
    endfunction

    // Directed vectors: A, B, Cin, Sub -> {Sum, Cout, Overflow, Zero}
    localparam logic [15:0] DA   [8] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0FFF, 16'h1234, 16'h8000, 16'h0000, 16'hFFFF};
    localparam logic [15:0] DB   [8] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h4321, 16'h0001, 16'h0000, 16'hFFFF};
    localparam logic        DCIN [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic        DSUB [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [18:0] DEXP [8] = '{
        {16'h0000, 1'b1, 1'b0, 1'b1}, {16'h8000, 1'b0, 1'b1, 1'b0},
        {16'hFFFE, 1'b0, 1'b0, 1'b0}, {16'h1000, 1'b0, 1'b0, 1'b0},
        {16'h5556, 1'b0, 1'b0, 1'b0}, {16'h7FFF, 1'b1, 1'b1, 1'b0},
        {16'h0000, 1'b1, 1'b0, 1'b1}, {16'hFFFF, 1'b1, 1'b0, 1'b0}};

    task automatic test_reset;
        #2 Reset_n = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({out_valid, Sum, Cout, Overflow, Zero} !== 20'd0)
            begin errors++; $display("FAIL reset16: got %h expected 0", {out_valid, Sum, Cout, Overflow, Zero}); end
        checks++;
        if ({w_out_valid, w_Sum, w_Cout, w_Overflow, w_Zero} !== 36'd0)
            begin errors++; $display("FAIL reset32: got %h expected 0", {w_out_valid, w_Sum, w_Cout, w_Overflow, w_Zero}); end
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (in_ready !== 1'b1 || w_in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, w_in_ready); end
    endtask

    task automatic test_directed;
        int lat;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            A = DA[i]; B = DB[i]; Cin = DCIN[i]; Sub = DSUB[i];
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge Clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin @(posedge Clk); #1; lat++; end
            checks++;
            if (lat !== LAT) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            checks++;
            if ({Sum, Cout, Overflow, Zero} !== DEXP[i])
                begin errors++; $display("FAIL dir_result[%0d]: got %h expected %h", i, {Sum, Cout, Overflow, Zero}, DEXP[i]); end
            @(posedge Clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_single[%0d]: out_valid %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_random;
        res_t q[$];
        res_t e;
        int sent = 0, got = 0, cyc = 0;
        localparam int N = 10000;
        while ((sent < N || q.size() > 0) && cyc < N + 100) begin
            @(negedge Clk);
            out_ready = 1'b1;
            if (sent < N) begin
                in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
                Cin = 1'($urandom); Sub = 1'($urandom);
            end else in_valid = 1'b0;
            #1;
            if (sent < N && cyc >= LAT) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL rnd_throughput: out_valid %b at cycle %0d expected 1", out_valid, cyc); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rnd_spurious: result %h with nothing expected", Sum); end
                else begin
                    e = q.pop_front();
                    if ({Sum, Cout, Overflow, Zero} !== {e.sum[15:0], e.cout, e.ovf, e.zero})
                        begin errors++; $display("FAIL rnd_result: got %h expected %h", {Sum, Cout, Overflow, Zero}, {e.sum[15:0], e.cout, e.ovf, e.zero}); end
                end
                got++;
            end
            if (in_valid && in_ready === 1'b1) begin q.push_back(model(16, {16'd0, A}, {16'd0, B}, Cin, Sub)); sent++; end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== N) begin errors++; $display("FAIL rnd_count: got %0d results expected %0d", got, N); end
    endtask

    task automatic test_backpressure;
        res_t q[$];
        res_t e;
        logic [19:0] held;
        int sent = 0, got = 0, cyc = 0;
        held = '0;
        while ((sent < 8 || q.size() > 0) && cyc < 60) begin
            @(negedge Clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
                Cin = 1'($urandom); Sub = 1'($urandom);
            end else in_valid = 1'b0;
            #1;
            if (cyc == 6) held = {out_valid, Sum, Cout, Overflow, Zero};
            if (cyc >= 6 && cyc <= 8) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b at cycle %0d expected 0", in_ready, cyc); end
            end
            if (cyc >= 7 && cyc <= 9) begin
                checks++;
                if ({out_valid, Sum, Cout, Overflow, Zero} !== held || held[19] !== 1'b1)
                    begin errors++; $display("FAIL bp_hold: got %h expected %h (valid)", {out_valid, Sum, Cout, Overflow, Zero}, held); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL bp_spurious: result %h with nothing expected", Sum); end
                else begin
                    e = q.pop_front();
                    if ({Sum, Cout, Overflow, Zero} !== {e.sum[15:0], e.cout, e.ovf, e.zero})
                        begin errors++; $display("FAIL bp_result: got %h expected %h", {Sum, Cout, Overflow, Zero}, {e.sum[15:0], e.cout, e.ovf, e.zero}); end
                end
                got++;
            end
            if (in_valid && in_ready === 1'b1) begin q.push_back(model(16, {16'd0, A}, {16'd0, B}, Cin, Sub)); sent++; end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got !== 8) begin errors++; $display("FAIL bp_count: got %0d results expected 8", got); end
    endtask

    task automatic test_reset_mid;
        res_t e;
        int lat;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            in_valid = 1'b1; out_ready = 1'b1; A = 16'($urandom); B = 16'($urandom); Cin = 1'b1; Sub = 1'b0;
        end
        @(negedge Clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: out_valid %b expected 1", out_valid); end
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, Sum, Cout, Overflow, Zero} !== 20'd0)
            begin errors++; $display("FAIL mid_reset: got %h expected 0", {out_valid, Sum, Cout, Overflow, Zero}); end
        #2 Reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                begin errors++; $display("FAIL mid_stale: out_valid %b in_ready %b expected 0/1", out_valid, in_ready); end
        end
        A = 16'h0F0F; B = 16'h00F1; Cin = 1'b0; Sub = 1'b1; in_valid = 1'b1;
        e = model(16, {16'd0, A}, {16'd0, B}, Cin, Sub);
        @(posedge Clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin @(posedge Clk); #1; lat++; end
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL mid_latency: got %0d expected %0d", lat, LAT); end
        checks++;
        if ({Sum, Cout, Overflow, Zero} !== {e.sum[15:0], e.cout, e.ovf, e.zero})
            begin errors++; $display("FAIL mid_result: got %h expected %h", {Sum, Cout, Overflow, Zero}, {e.sum[15:0], e.cout, e.ovf, e.zero}); end
        @(posedge Clk); #1;
    endtask

    task automatic test_wide;
        res_t q[$];
        res_t e;
        int lat, sent = 0, got = 0, cyc = 0;
        logic [31:0] wa [2] = '{32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [34:0] wexp [2] = '{{32'h00000000, 1'b1, 1'b0, 1'b1}, {32'h80000000, 1'b0, 1'b1, 1'b0}};
        localparam int N = 3000;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            w_A = wa[i]; w_B = 32'h1; w_Cin = 1'b0; w_Sub = 1'b0; w_in_valid = 1'b1; w_out_ready = 1'b1;
            @(posedge Clk); #1;
            w_in_valid = 1'b0;
            lat = 1;
            while (w_out_valid !== 1'b1 && lat < 20) begin @(posedge Clk); #1; lat++; end
            checks++;
            if (lat !== LAT2) begin errors++; $display("FAIL wide_latency[%0d]: got %0d expected %0d", i, lat, LAT2); end
            checks++;
            if ({w_Sum, w_Cout, w_Overflow, w_Zero} !== wexp[i])
                begin errors++; $display("FAIL wide_dir[%0d]: got %h expected %h", i, {w_Sum, w_Cout, w_Overflow, w_Zero}, wexp[i]); end
            @(posedge Clk); #1;
        end
        while ((sent < N || q.size() > 0) && cyc < 4 * N) begin
            @(negedge Clk);
            w_out_ready = ($urandom_range(0, 3) != 0);
            if (sent < N) begin
                w_in_valid = ($urandom_range(0, 3) != 0); w_A = $urandom; w_B = $urandom;
                w_Cin = 1'($urandom); w_Sub = 1'($urandom);
            end else w_in_valid = 1'b0;
            #1;
            if (w_out_valid === 1'b1 && w_out_ready) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL wide_spurious: result %h with nothing expected", w_Sum); end
                else begin
                    e = q.pop_front();
                    if ({w_Sum, w_Cout, w_Overflow, w_Zero} !== {e.sum, e.cout, e.ovf, e.zero})
                        begin errors++; $display("FAIL wide_rnd: got %h expected %h", {w_Sum, w_Cout, w_Overflow, w_Zero}, {e.sum, e.cout, e.ovf, e.zero}); end
                end
                got++;
            end
            if (w_in_valid && w_in_ready === 1'b1) begin q.push_back(model(32, w_A, w_B, w_Cin, w_Sub)); sent++; end
            cyc++;
        end
        w_in_valid = 1'b0;
        checks++;
        if (got !== N) begin errors++; $display("FAIL wide_count: got %0d results expected %0d", got, N); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "time limit");
    end

    initial begin
        Reset_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_A = '0; w_B = '0; w_Cin = 1'b0; w_Sub = 1'b0;
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_mid;
        test_wide;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
